// File: rtl/udp_pkg.sv
// rtl/udp_pkg.sv - shared state encoding and constants for the UDP transmit scheduler
package udp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_BURST = 2'd2,
        ST_GAP   = 2'd3
    } sched_state_e;

    localparam int GAP_CYCLES_DEF     = 3;
    localparam int MAX_LEN_DEF        = 1472;
    localparam int UDP_HDR_BYTES      = 8;
    localparam int FIRST_WORD_TIMEOUT = 16;

    // Payload bytes to 32-bit words, rounded up; 17-bit sum so 0xFFFF cannot wrap.
    function automatic logic [14:0] len_to_words(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'd3;
        return sum[16:2];
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick: first set request at or after ptr
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   idx,
    output logic             any
);

    always_comb begin
        logic [IDW:0] pos;
        logic         found;
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pos = {1'b0, ptr} + (IDW+1)'(i);
            if (pos >= (IDW+1)'(N_REQ)) begin
                pos = pos - (IDW+1)'(N_REQ);
            end
            if (!found && req[pos[IDW-1:0]]) begin
                found               = 1'b1;
                gnt[pos[IDW-1:0]]   = 1'b1;
                idx                 = pos[IDW-1:0];
            end
        end
        any = found;
    end

endmodule

// File: rtl/udp_tx_sched.sv
// rtl/udp_tx_sched.sv - round-robin scheduler feeding one udp_send from N_REQ requesters
module udp_tx_sched
    import udp_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int IDW        = 2,
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int MAX_LEN    = MAX_LEN_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [N_REQ-1:0]  req,
    input  logic [32*N_REQ-1:0] req_ip,
    input  logic [16*N_REQ-1:0] req_port,
    input  logic [16*N_REQ-1:0] req_len,
    input  logic [32*N_REQ-1:0] req_data,
    input  logic [N_REQ-1:0]  req_valid,
    output logic [N_REQ-1:0]  grant,
    output logic              us_valid,
    output logic [31:0]       us_data,
    output logic [31:0]       us_ip,
    output logic [15:0]       us_port,
    output logic [15:0]       us_len,
    output logic              busy,
    output logic [IDW-1:0]    active_id,
    output logic              pkt_done,
    output logic              err
);

    logic [31:0] ip_a   [N_REQ];
    logic [15:0] port_a [N_REQ];
    logic [15:0] len_a  [N_REQ];
    logic [31:0] data_a [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_slice
        assign ip_a[g]   = req_ip[g*32 +: 32];
        assign port_a[g] = req_port[g*16 +: 16];
        assign len_a[g]  = req_len[g*16 +: 16];
        assign data_a[g] = req_data[g*32 +: 32];
    end

    sched_state_e   state_q, state_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0] active_id_q, active_id_d;
    logic [14:0]    words_q, words_d;
    logic [14:0]    cnt_q, cnt_d;
    logic [4:0]     wait_q, wait_d;
    logic [7:0]     gap_q, gap_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic           us_valid_q, us_valid_d;
    logic [31:0]    us_data_q, us_data_d;
    logic [31:0]    us_ip_q, us_ip_d;
    logic [15:0]    us_port_q, us_port_d;
    logic [15:0]    us_len_q, us_len_d;
    logic           busy_q, busy_d;
    logic           pkt_done_q, pkt_done_d;
    logic           err_q, err_d;

    logic [N_REQ-1:0] arb_gnt;
    logic [IDW-1:0]   arb_idx;
    logic             arb_any;

    rr_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) u_arb (
        .req (req),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx),
        .any (arb_any)
    );

    logic [15:0] len_sel;
    logic        valid_sel;
    logic [31:0] data_sel;
    logic        len_bad;

    assign len_sel   = len_a[active_id_q];
    assign valid_sel = req_valid[active_id_q];
    assign data_sel  = data_a[active_id_q];
    assign len_bad   = (len_sel == 16'd0) || (len_sel > 16'(MAX_LEN));

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        active_id_d = active_id_q;
        words_d     = words_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        gap_d       = gap_q;
        grant_d     = grant_q;
        us_valid_d  = 1'b0;
        us_data_d   = us_data_q;
        us_ip_d     = us_ip_q;
        us_port_d   = us_port_q;
        us_len_d    = us_len_q;
        pkt_done_d  = 1'b0;
        err_d       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    active_id_d = arb_idx;
                    rr_ptr_d    = (arb_idx == IDW'(N_REQ-1)) ? '0 : arb_idx + 1'b1;
                    state_d     = ST_LOAD;
                end
            end
            ST_LOAD: begin
                us_ip_d   = ip_a[active_id_q];
                us_port_d = port_a[active_id_q];
                us_len_d  = len_sel;
                words_d   = len_to_words(len_sel);
                cnt_d     = '0;
                wait_d    = '0;
                gap_d     = '0;
                if (len_bad) begin
                    err_d   = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    grant_d              = '0;
                    grant_d[active_id_q] = 1'b1;
                    state_d              = ST_BURST;
                end
            end
            ST_BURST: begin
                us_valid_d = valid_sel;
                if (valid_sel) begin
                    us_data_d = data_sel;
                    cnt_d     = cnt_q + 15'd1;
                    if (cnt_q + 15'd1 == words_q) begin
                        grant_d    = '0;
                        pkt_done_d = 1'b1;
                        state_d    = ST_GAP;
                    end
                end else if (cnt_q != 15'd0 || wait_q == 5'(FIRST_WORD_TIMEOUT-1)) begin
                    // Gap in a started burst, or requester never started: abandon it.
                    grant_d = '0;
                    err_d   = 1'b1;
                    state_d = ST_GAP;
                end else begin
                    wait_d = wait_q + 5'd1;
                end
            end
            ST_GAP: begin
                if (gap_q == 8'(GAP_CYCLES-1)) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= '0;
            active_id_q <= '0;
            words_q     <= '0;
            cnt_q       <= '0;
            wait_q      <= '0;
            gap_q       <= '0;
            grant_q     <= '0;
            us_valid_q  <= 1'b0;
            us_data_q   <= '0;
            us_ip_q     <= '0;
            us_port_q   <= '0;
            us_len_q    <= '0;
            busy_q      <= 1'b0;
            pkt_done_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            active_id_q <= active_id_d;
            words_q     <= words_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            gap_q       <= gap_d;
            grant_q     <= grant_d;
            us_valid_q  <= us_valid_d;
            us_data_q   <= us_data_d;
            us_ip_q     <= us_ip_d;
            us_port_q   <= us_port_d;
            us_len_q    <= us_len_d;
            busy_q      <= busy_d;
            pkt_done_q  <= pkt_done_d;
            err_q       <= err_d;
        end
    end

    assign grant     = grant_q;
    assign us_valid  = us_valid_q;
    assign us_data   = us_data_q;
    assign us_ip     = us_ip_q;
    assign us_port   = us_port_q;
    assign us_len    = us_len_q;
    assign busy      = busy_q;
    assign active_id = active_id_q;
    assign pkt_done  = pkt_done_q;
    assign err       = err_q;

endmodule
